// File: rtl/geig_frame_packer.sv
// geig_frame_packer: turns each 10 Hz tick into a byte-serial frame
//   A5 5A SEQ D0..D9 [CSUM] with a valid/ready handshake on the byte port.
// Optional feature macro: GEIG_FRAME_CSUM_EN appends an 8-bit checksum
// (sum of SEQ and the ten data bytes) as the last byte of the frame.
module geig_frame_packer (
    input  logic        CLK_1MHZ,
    input  logic        RESET,
    input  logic        CLK_10HZ,
    input  logic [79:0] G_DATA_STACK,
    input  logic        BYTE_READY,
    output logic [7:0]  BYTE_OUT,
    output logic        BYTE_VALID,
    output logic        FRAME_ACTIVE,
    output logic [7:0]  OVERRUN_CNT
);

    localparam int unsigned DATA_W = 80;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [BYTE_W-1:0] HDR0_BYTE = 8'hA5;
    localparam logic [BYTE_W-1:0] HDR1_BYTE = 8'h5A;
    localparam logic [IDX_W-1:0]  LAST_IDX  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_SEQ,
        ST_DATA
`ifdef GEIG_FRAME_CSUM_EN
        ,
        ST_CSUM
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic [1:0]          r_warm;
    logic                r_trig;
    logic [DATA_W-1:0]   r_buf;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nx;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [DATA_W-1:0]   w_data_sh;
    logic [BYTE_W-1:0]   r_byte;
    logic [BYTE_W-1:0]   w_byte_nx;
    logic                r_valid;
    logic                w_valid_nx;
    logic                r_active;
    logic                w_active_nx;
    logic [BYTE_W-1:0]   r_seq;
    logic [BYTE_W-1:0]   w_seq_nx;
    logic [BYTE_W-1:0]   r_ovr;
    logic                w_load;
    logic                w_xfer;
`ifdef GEIG_FRAME_CSUM_EN
    logic [BYTE_W-1:0]   r_csum;
    logic [BYTE_W-1:0]   w_csum_nx;
`endif

    assign BYTE_OUT     = r_byte;
    assign BYTE_VALID   = r_valid;
    assign FRAME_ACTIVE = r_active;
    assign OVERRUN_CNT  = r_ovr;

    assign w_xfer    = r_valid & BYTE_READY;
    assign w_idx_inc = IDX_W'(r_idx + 4'd1);
    assign w_data_sh = r_buf << {w_idx_inc, 3'b000};

    // Synchronise the tick and register a one-cycle rising-edge pulse; the
    // warm-up count hides a level that is already high when reset releases.
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_warm  <= 2'd0;
            r_trig  <= 1'b0;
        end else begin
            r_sync1 <= CLK_10HZ;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_warm  <= (r_warm == 2'd3) ? 2'd3 : 2'(r_warm + 2'd1);
            r_trig  <= r_sync2 & ~r_sync3 & (r_warm == 2'd3);
        end
    end

    // State register with its registered outputs, buffer and sequence.
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_buf    <= '0;
            r_idx    <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_seq    <= '0;
`ifdef GEIG_FRAME_CSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_byte   <= w_byte_nx;
            r_valid  <= w_valid_nx;
            r_active <= w_active_nx;
            r_seq    <= w_seq_nx;
`ifdef GEIG_FRAME_CSUM_EN
            r_csum   <= w_csum_nx;
`endif
            if (w_load) begin
                r_buf <= G_DATA_STACK;
            end
        end
    end

    // Next-state and next-output logic; each byte advances only on a transfer.
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_byte_nx   = r_byte;
        w_valid_nx  = r_valid;
        w_active_nx = r_active;
        w_seq_nx    = r_seq;
        w_load      = 1'b0;
`ifdef GEIG_FRAME_CSUM_EN
        w_csum_nx   = r_csum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_trig) begin
                    w_state_nx  = ST_HDR0;
                    w_load      = 1'b1;
                    w_idx_nx    = '0;
                    w_byte_nx   = HDR0_BYTE;
                    w_valid_nx  = 1'b1;
                    w_active_nx = 1'b1;
                end
            end
            ST_HDR0: begin
                if (w_xfer) begin
                    w_state_nx = ST_HDR1;
                    w_byte_nx  = HDR1_BYTE;
                end
            end
            ST_HDR1: begin
                if (w_xfer) begin
                    w_state_nx = ST_SEQ;
                    w_byte_nx  = r_seq;
`ifdef GEIG_FRAME_CSUM_EN
                    w_csum_nx  = r_seq;
`endif
                end
            end
            ST_SEQ: begin
                if (w_xfer) begin
                    w_state_nx = ST_DATA;
                    w_idx_nx   = '0;
                    w_byte_nx  = r_buf[DATA_W-1 -: BYTE_W];
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
`ifdef GEIG_FRAME_CSUM_EN
                    w_csum_nx = BYTE_W'(r_csum + r_byte);
`endif
                    if (r_idx == LAST_IDX) begin
`ifdef GEIG_FRAME_CSUM_EN
                        w_state_nx = ST_CSUM;
                        w_byte_nx  = BYTE_W'(r_csum + r_byte);
`else
                        w_state_nx  = ST_IDLE;
                        w_byte_nx   = '0;
                        w_valid_nx  = 1'b0;
                        w_active_nx = 1'b0;
                        w_seq_nx    = BYTE_W'(r_seq + 8'd1);
`endif
                    end else begin
                        w_idx_nx  = w_idx_inc;
                        w_byte_nx = w_data_sh[DATA_W-1 -: BYTE_W];
                    end
                end
            end
`ifdef GEIG_FRAME_CSUM_EN
            ST_CSUM: begin
                if (w_xfer) begin
                    w_state_nx  = ST_IDLE;
                    w_byte_nx   = '0;
                    w_valid_nx  = 1'b0;
                    w_active_nx = 1'b0;
                    w_seq_nx    = BYTE_W'(r_seq + 8'd1);
                end
            end
`endif
            default: begin
                w_state_nx  = ST_IDLE;
                w_valid_nx  = 1'b0;
                w_active_nx = 1'b0;
            end
        endcase
    end

    // Count triggers that arrive while a frame is still in flight, saturating.
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            r_ovr <= '0;
        end else if (r_trig && (r_state != ST_IDLE) && (r_ovr != 8'hFF)) begin
            r_ovr <= BYTE_W'(r_ovr + 8'd1);
        end
    end

endmodule

// File: tb/tb_geig_frame_packer.sv
// Directed bench for geig_frame_packer with a byte scoreboard.
// Honours GEIG_FRAME_CSUM_EN in the same way as the design.
module tb_geig_frame_packer;

`ifdef GEIG_FRAME_CSUM_EN
    localparam int FRAME_LEN = 14;
`else
    localparam int FRAME_LEN = 13;
`endif

    logic        clk;
    logic        rst;
    logic        tick_10hz;
    logic [79:0] data;
    logic        ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_active;
    logic [7:0]  overrun_cnt;

    int          n_pass;
    int          n_total;
    logic [7:0]  sb[$];
    logic [7:0]  exp_seq;

    geig_frame_packer dut (
        .CLK_1MHZ     (clk),
        .RESET        (rst),
        .CLK_10HZ     (tick_10hz),
        .G_DATA_STACK (data),
        .BYTE_READY   (ready),
        .BYTE_OUT     (byte_out),
        .BYTE_VALID   (byte_valid),
        .FRAME_ACTIVE (frame_active),
        .OVERRUN_CNT  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Expected frame for the given payload, stamped with the model sequence.
    task automatic push_frame(input logic [79:0] d);
        logic [7:0] sum;
        sb.push_back(8'hA5);
        sb.push_back(8'h5A);
        sb.push_back(exp_seq);
        sum = exp_seq;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(d[79 - 8*i -: 8]);
            sum = 8'(sum + d[79 - 8*i -: 8]);
        end
`ifdef GEIG_FRAME_CSUM_EN
        sb.push_back(sum);
`endif
        exp_seq = 8'(exp_seq + 8'd1);
    endtask

    // One clock; score any byte transferred on this edge and check stall hold.
    task automatic tick();
        logic       xfer;
        logic       stall;
        logic [7:0] b;
        logic [8:0] e;
        xfer  = byte_valid && ready;
        stall = byte_valid && !ready;
        b     = byte_out;
        @(posedge clk);
        #1;
        if (xfer) begin
            if (sb.size() > 0) e = {1'b0, sb.pop_front()};
            else               e = 9'h100;
            chk("byte", 32'(b), 32'(e));
        end
        if (stall && !rst) begin
            chk("hold_byte", 32'(byte_out), 32'(b));
            chk("hold_valid", 32'(byte_valid), 32'd1);
        end
    endtask

    task automatic run_frame();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 64) begin
            tick();
            n++;
        end
        chk("frame_done", 32'(sb.size()), 32'd0);
        chk("valid_after_last", 32'(byte_valid), 32'd0);
        chk("active_after_last", 32'(frame_active), 32'd0);
    endtask

    task automatic lower_tick();
        tick_10hz = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        exp_seq   = 8'h00;
        rst       = 1'b1;
        tick_10hz = 1'b1;
        data      = 80'h0102030405060708090A;
        ready     = 1'b1;

        // Reset values, and a tick level already high at release is ignored
        repeat (3) tick();
        chk("rst_byte", 32'(byte_out), 32'h00);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_active", 32'(frame_active), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        chk("high_at_release_valid", 32'(byte_valid), 32'd0);
        chk("high_at_release_active", 32'(frame_active), 32'd0);
        lower_tick();

        // Basic frame, ready always high, first valid four clocks after the edge
        tick_10hz = 1'b1;
        push_frame(data);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("latency_c%0d", i), 32'(byte_valid), 32'd0);
        end
        tick();
        chk("latency_c4_valid", 32'(byte_valid), 32'd1);
        chk("latency_c4_byte", 32'(byte_out), 32'hA5);
        chk("latency_c4_active", 32'(frame_active), 32'd1);
        run_frame();
        lower_tick();

        // Stall five cycles on data index 3
        tick_10hz = 1'b1;
        push_frame(data);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sb.size() == FRAME_LEN - 6) break;
        end
        chk("reach_d3", 32'(sb.size()), 32'(FRAME_LEN - 6));
        chk("d3_byte", 32'(byte_out), 32'h04);
        ready = 1'b0;
        repeat (5) tick();
        chk("d3_after_stall", 32'(byte_out), 32'h04);
        ready = 1'b1;
        run_frame();
        lower_tick();

        // Reset, then 257 back-to-back frames: sequence wraps 0xFF -> 0x00
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_seq = 8'h00;
        repeat (4) tick();
        for (int f = 1; f <= 257; f++) begin
            data = {$urandom, $urandom, 16'($urandom)};
            tick_10hz = 1'b1;
            push_frame(data);
            run_frame();
            lower_tick();
        end
        chk("seq_model_wrapped", 32'(exp_seq), 32'h01);

        // Trigger landing on the final transfer is an overrun, not a new frame
        data = 80'hF0E1D2C3B4A596877869;
        tick_10hz = 1'b1;
        push_frame(data);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sb.size() == 1) break;
        end
        chk("reach_last", 32'(sb.size()), 32'd1);
        ready = 1'b0;
        lower_tick();
        tick_10hz = 1'b1;
        repeat (3) tick();
        ready = 1'b1;
        tick();
        chk("coincide_sb_empty", 32'(sb.size()), 32'd0);
        chk("coincide_valid", 32'(byte_valid), 32'd0);
        chk("coincide_active", 32'(frame_active), 32'd0);
        chk("coincide_ovr", 32'(overrun_cnt), 32'd1);
        repeat (6) tick();
        chk("coincide_no_frame", 32'(byte_valid), 32'd0);
        lower_tick();

        // Ready held low across 300 rises: overruns saturate, frame intact
        ready = 1'b0;
        data  = 80'h112233445566778899AA;
        tick_10hz = 1'b1;
        push_frame(data);
        repeat (4) tick();
        chk("ovr_first_valid", 32'(byte_valid), 32'd1);
        lower_tick();
        for (int r = 1; r < 300; r++) begin
            data = {$urandom, $urandom, 16'($urandom)};
            tick_10hz = 1'b1;
            repeat (4) tick();
            lower_tick();
            if (r == 1) chk("ovr_step", 32'(overrun_cnt), 32'd2);
        end
        chk("ovr_saturated", 32'(overrun_cnt), 32'd255);
        ready = 1'b1;
        run_frame();

        // Reset during data index 5 aborts the frame; next frame restarts SEQ
        data = 80'h0102030405060708090A;
        tick_10hz = 1'b1;
        push_frame(data);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sb.size() == FRAME_LEN - 8) break;
        end
        chk("reach_d5", 32'(sb.size()), 32'(FRAME_LEN - 8));
        chk("d5_byte", 32'(byte_out), 32'h06);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(byte_valid), 32'd0);
        chk("abort_active", 32'(frame_active), 32'd0);
        chk("abort_byte", 32'(byte_out), 32'h00);
        chk("abort_ovr", 32'(overrun_cnt), 32'd0);
        sb.delete();
        exp_seq = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("post_abort_idle", 32'(byte_valid), 32'd0);
        lower_tick();
        tick_10hz = 1'b1;
        push_frame(data);
        repeat (4) tick();
        chk("post_abort_hdr", 32'(byte_out), 32'hA5);
        run_frame();
        lower_tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/geig_frame_packer.md
GEIG_FRAME_PACKER -- requirements
Module: geig_frame_packer

Interface
REQ-001 SHALL have no parameters; the frame format is fixed by this document and by the Configuration macro.
REQ-002 SHALL have port CLK_1MHZ, input, 1: the single clock; all state advances on its rising edge.
REQ-003 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port CLK_10HZ, input, 1: 10 Hz tick level from the clock divider; treated as asynchronous and sampled in the CLK_1MHZ domain.
REQ-005 SHALL have port G_DATA_STACK, input, 80: geiger data stack from the data-handling stage.
REQ-006 SHALL have port BYTE_READY, input, 1: the downstream sink can accept a byte.
REQ-007 SHALL have port BYTE_OUT, output, 8: current frame byte.
REQ-008 SHALL have port BYTE_VALID, output, 1: BYTE_OUT holds a valid byte.
REQ-009 SHALL have port FRAME_ACTIVE, output, 1: high from frame capture until the last byte transfers.
REQ-010 SHALL have port OVERRUN_CNT, output, 8: count of dropped triggers.

Function
REQ-011 SHALL pass CLK_10HZ through a 2-flop synchronizer, and a third flop SHALL form a one-cycle rising-edge pulse TRIG.
REQ-012 SHALL latch G_DATA_STACK into an internal 80-bit buffer on the cycle TRIG is accepted; buffer contents SHALL NOT change for the rest of the frame.
REQ-013 SHALL implement FSM states IDLE, HDR0, HDR1, SEQ, DATA, CSUM.
REQ-014 SHALL advance IDLE->HDR0 on an accepted TRIG.
REQ-015 SHALL assert BYTE_VALID with BYTE_OUT=0xA5 in the cycle after acceptance.
REQ-016 SHALL send bytes in this order: HDR0=0xA5, HDR1=0x5A, SEQ=frame sequence number, DATA=10 bytes MSB first (G_DATA_STACK[79:72] first, [7:0] last), then CSUM when enabled.
REQ-017 SHALL complete a transfer only in a cycle where BYTE_VALID and BYTE_READY are both high; the next byte SHALL be presented in the following cycle.
REQ-018 SHALL hold BYTE_OUT stable while BYTE_VALID=1 and BYTE_READY=0, and SHALL keep BYTE_VALID high until the transfer completes.
REQ-019 SHALL use a 4-bit data byte index 0..9; the transfer of index 9 SHALL exit DATA.
REQ-020 SHALL return to IDLE and deassert BYTE_VALID and FRAME_ACTIVE in the cycle after the final byte transfers.
REQ-021 SHALL increment the sequence number by 1 mod 256 (255->0) when a frame's final byte transfers.
REQ-022 SHALL, on a TRIG while FRAME_ACTIVE=1, drop the trigger, leave the frame unaffected, and increment OVERRUN_CNT, saturating at 255.
REQ-023 SHALL treat a TRIG coinciding with the final byte transfer as an overrun, not as a new frame.
REQ-024 SHALL accept a BYTE_READY that is high before BYTE_VALID rises.
REQ-025 SHALL let BYTE_READY low stall the frame indefinitely, with no timeout.

Reset
REQ-026 SHALL, while RESET=1, force: FSM=IDLE, BYTE_OUT=0x00, BYTE_VALID=0, FRAME_ACTIVE=0, OVERRUN_CNT=0, sequence=0x00, synchronizer flops=0, buffer=0.
REQ-027 SHALL abort any in-progress frame on RESET; after release, the first frame SHALL start at HDR0 with SEQ=0x00.
REQ-028 SHALL ignore an already-high CLK_10HZ level at reset release, so only a subsequent rising edge produces TRIG.

Configuration
REQ-029 SHALL compile the checksum with macro GEIG_FRAME_CSUM_EN defined: the frame is 14 bytes, and CSUM = 8-bit sum mod 256 of the SEQ byte and the 10 DATA bytes, sent last.
REQ-030 SHALL omit the CSUM state and checksum logic when GEIG_FRAME_CSUM_EN is undefined: the frame is 13 bytes and the final transfer is DATA index 9.

Verification
REQ-031 SHALL cover: reset; BYTE_READY=1; G_DATA_STACK=0x0102030405060708090A; one CLK_10HZ rise -> bytes A5 5A 00 01..0A 37 (checksum enabled), BYTE_VALID first high 4 cycles after the CLK_10HZ edge.
REQ-032 SHALL cover: same stimulus with BYTE_READY=0 for 5 cycles during DATA index 3 -> BYTE_OUT=0x04 stable throughout, no byte skipped or duplicated.
REQ-033 SHALL cover: 257 back-to-back frames -> SEQ of frames 256 and 257 equal 0xFF then 0x00.
REQ-034 SHALL cover: BYTE_READY held low and 300 CLK_10HZ rises -> OVERRUN_CNT=255 (saturated), first frame still intact once ready.
REQ-035 SHALL cover: RESET asserted at DATA index 5 -> BYTE_VALID=0 immediately; next frame SEQ=0x00, starting at 0xA5.
REQ-036 SHALL cover: build without GEIG_FRAME_CSUM_EN -> 13-byte frame, FRAME_ACTIVE low the cycle after byte 0x0A transfers.
